// File: rtl/dmem_pkg.sv
// Shared decode constants for the data-memory responder: region nibbles,
// I/O register offsets and STATUS bit positions.
package dmem_pkg;

    localparam logic [3:0] RAM_REGION = 4'h0;
    localparam logic [3:0] IO_REGION  = 4'h8;

    localparam logic [7:0] GPIO_OFS   = 8'h00;
    localparam logic [7:0] TIMER_OFS  = 8'h04;
    localparam logic [7:0] TXDATA_OFS = 8'h08;
    localparam logic [7:0] STATUS_OFS = 8'h0C;
    localparam logic [7:0] CMP_OFS    = 8'h10;

    localparam int STAT_EMPTY   = 0;
    localparam int STAT_FULL    = 1;
    localparam int STAT_OVF     = 2;
    localparam int STAT_CMP     = 3;
    localparam int STAT_CNT_LSB = 8;

    // Byte-lane bits of the offset are ignored, so registers match on the word index only.
    function automatic logic io_hit(input logic [7:0] ofs, input logic [7:0] reg_ofs);
        return ofs[7:2] == reg_ofs[7:2];
    endfunction

endpackage

// File: rtl/dmem_responder_tx_fifo.sv
// Byte TX FIFO toward the serial link: storage, wrapping pointers, count,
// push/pop arbitration (push into a full FIFO succeeds only alongside a pop).
module tx_fifo #(
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [7:0]       push_data,
    input  logic             pop_ready,
    output logic [7:0]       head_data,
    output logic             valid,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             rejected
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             pop;
    logic             accept;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty     = (count == '0);
    assign full      = (count == CNT_W'(DEPTH));
    assign valid     = ~empty;
    assign pop       = valid & pop_ready;
    assign accept    = push & (~full | pop);
    assign rejected  = push & ~accept;
    assign head_data = empty ? 8'h00 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (accept) wr_ptr <= ptr_next(wr_ptr);
            if (pop)    rd_ptr <= ptr_next(rd_ptr);
            case ({accept, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Memory-stage data port: word RAM plus an I/O window (GPIO, timer, TX FIFO, STATUS).
// Define DMEM_TIMER_CMP_EN to add the CMP register, cmp_hit status bit and irq.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int RAM_AW     = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int GPIO_W     = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_we,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic [31:0]       mem_rdata,
    output logic [GPIO_W-1:0] gpio_out,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              irq
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]       ram [2**RAM_AW];
    logic [RAM_AW-1:0] ram_idx;
    logic [7:0]        io_ofs;
    logic              sel_ram;
    logic              sel_io;
    logic              wr_gpio;
    logic              wr_timer;
    logic              wr_txdata;
    logic              wr_status;
    logic [31:0]       timer;
    logic              ovf;
    logic              cmp_hit;
    logic [31:0]       status_word;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_rejected;
    logic              unused_addr_bits;

    assign unused_addr_bits = &{1'b0, mem_addr[27:RAM_AW+2], mem_addr[1:0]};

    assign ram_idx   = mem_addr[RAM_AW+1:2];
    assign io_ofs    = mem_addr[7:0];
    assign sel_ram   = (mem_addr[31:28] == RAM_REGION);
    assign sel_io    = (mem_addr[31:28] == IO_REGION);
    assign wr_gpio   = mem_we & sel_io & io_hit(io_ofs, GPIO_OFS);
    assign wr_timer  = mem_we & sel_io & io_hit(io_ofs, TIMER_OFS);
    assign wr_txdata = mem_we & sel_io & io_hit(io_ofs, TXDATA_OFS);
    assign wr_status = mem_we & sel_io & io_hit(io_ofs, STATUS_OFS);

    always_ff @(posedge clk) begin
        if (mem_we && sel_ram) begin
            ram[ram_idx] <= mem_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gpio_out <= '0;
            timer    <= '0;
            ovf      <= 1'b0;
        end else begin
            if (wr_gpio) gpio_out <= mem_wdata[GPIO_W-1:0];
            timer <= wr_timer ? mem_wdata : timer + 32'd1;
            if (fifo_rejected)
                ovf <= 1'b1;
            else if (wr_status && mem_wdata[STAT_OVF])
                ovf <= 1'b0;
        end
    end

`ifdef DMEM_TIMER_CMP_EN
    logic [31:0] cmp_val;
    logic        wr_cmp;

    assign wr_cmp = mem_we & sel_io & io_hit(io_ofs, CMP_OFS);

    // A match sets cmp_hit one cycle later and beats a same-cycle clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cmp_val <= 32'hFFFF_FFFF;
            cmp_hit <= 1'b0;
        end else begin
            if (wr_cmp) cmp_val <= mem_wdata;
            if (timer == cmp_val)
                cmp_hit <= 1'b1;
            else if (wr_status && mem_wdata[STAT_CMP])
                cmp_hit <= 1'b0;
        end
    end
`else
    assign cmp_hit = 1'b0;
`endif

    assign irq = cmp_hit;

    always_comb begin
        status_word                 = '0;
        status_word[STAT_EMPTY]     = fifo_empty;
        status_word[STAT_FULL]      = fifo_full;
        status_word[STAT_OVF]       = ovf;
        status_word[STAT_CMP]       = cmp_hit;
        status_word[STAT_CNT_LSB+:8] = 8'(fifo_count);
    end

    always_comb begin
        mem_rdata = '0;
        if (sel_ram) begin
            mem_rdata = ram[ram_idx];
        end else if (sel_io) begin
            if (io_hit(io_ofs, GPIO_OFS))
                mem_rdata = 32'(gpio_out);
            else if (io_hit(io_ofs, TIMER_OFS))
                mem_rdata = timer;
            else if (io_hit(io_ofs, STATUS_OFS))
                mem_rdata = status_word;
`ifdef DMEM_TIMER_CMP_EN
            else if (io_hit(io_ofs, CMP_OFS))
                mem_rdata = cmp_val;
`endif
        end
    end

    tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_tx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (wr_txdata),
        .push_data (mem_wdata[7:0]),
        .pop_ready (tx_ready),
        .head_data (tx_data),
        .valid     (tx_valid),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .rejected  (fifo_rejected)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: queue/array reference model checked every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_dmem_responder;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_we = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic [31:0] mem_rdata;
    logic [7:0]  gpio_out;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic        irq;

    int vectors = 0;
    int miscompares = 0;

    dmem_responder #(
        .RAM_AW     (8),
        .FIFO_DEPTH (DEPTH),
        .GPIO_W     (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .gpio_out  (gpio_out),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [31:0] m_ram [int];
    logic [7:0]  m_gpio;
    logic [31:0] m_timer;
    logic [31:0] m_cmp;
    logic        m_ovf;
    logic        m_hit;
    logic [7:0]  m_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_gpio  = '0;
        m_timer = '0;
        m_cmp   = 32'hFFFF_FFFF;
        m_ovf   = 1'b0;
        m_hit   = 1'b0;
        m_q.delete();
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a, output bit known);
        logic [31:0] st;
        known = 1'b1;
        if (a[31:28] == 4'h0) begin
            if (m_ram.exists(int'(a[9:2]))) return m_ram[int'(a[9:2])];
            known = 1'b0;
            return '0;
        end
        if (a[31:28] != 4'h8) return '0;
        case (a[7:0] & 8'hFC)
            8'h00: return {24'h0, m_gpio};
            8'h04: return m_timer;
            8'h0C: begin
                st = '0;
                st[0] = (m_q.size() == 0);
                st[1] = (m_q.size() == DEPTH);
                st[2] = m_ovf;
                st[3] = m_hit;
                st[15:8] = 8'(m_q.size());
                return st;
            end
`ifdef DMEM_TIMER_CMP_EN
            8'h10: return m_cmp;
`endif
            default: return '0;
        endcase
    endfunction

    function automatic void model_step();
        bit          pop;
        bit          hit_set;
        bit          clr_hit;
        int          old_size;
        logic [31:0] t_next;
        old_size = m_q.size();
        pop      = (old_size != 0) && tx_ready;
        hit_set  = 1'b0;
`ifdef DMEM_TIMER_CMP_EN
        hit_set  = (m_timer == m_cmp);
`endif
        clr_hit  = 1'b0;
        t_next   = m_timer + 32'd1;
        if (pop) void'(m_q.pop_front());
        if (mem_we) begin
            if (mem_addr[31:28] == 4'h0) begin
                m_ram[int'(mem_addr[9:2])] = mem_wdata;
            end else if (mem_addr[31:28] == 4'h8) begin
                case (mem_addr[7:0] & 8'hFC)
                    8'h00: m_gpio = mem_wdata[7:0];
                    8'h04: t_next = mem_wdata;
                    8'h08: begin
                        if (old_size < DEPTH || pop) m_q.push_back(mem_wdata[7:0]);
                        else m_ovf = 1'b1;
                    end
                    8'h0C: begin
                        if (mem_wdata[2]) m_ovf = 1'b0;
                        if (mem_wdata[3]) clr_hit = 1'b1;
                    end
`ifdef DMEM_TIMER_CMP_EN
                    8'h10: m_cmp = mem_wdata;
`endif
                    default: ;
                endcase
            end
        end
        m_timer = t_next;
        m_hit   = hit_set | (m_hit & ~clr_hit);
    endfunction

    always @(posedge clk) begin
        if (!reset) model_step();
    end

    // Every-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        bit          known;
        logic [31:0] exp;
        exp = m_read(mem_addr, known);
        if (known) check("rdata", mem_rdata, exp);
        check("gpio", 32'(gpio_out), 32'(m_gpio));
        check("tx_valid", 32'(tx_valid), 32'(m_q.size() != 0));
        check("tx_data", 32'(tx_data), (m_q.size() != 0) ? 32'(m_q[0]) : 32'h0);
        check("irq", 32'(irq), 32'(m_hit));
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        mem_we    = 1'b1;
        mem_addr  = a;
        mem_wdata = d;
        cyc();
        mem_we    = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string name);
        mem_we   = 1'b0;
        mem_addr = a;
        @(negedge clk);
        check(name, mem_rdata, exp);
        cyc();
    endtask

    task automatic drain_expect(input logic [7:0] exp, input string name);
        @(negedge clk);
        check(name, 32'(tx_data), 32'(exp));
        cyc();
    endtask

    localparam logic [31:0] A_GPIO   = 32'h8000_0000;
    localparam logic [31:0] A_TIMER  = 32'h8000_0004;
    localparam logic [31:0] A_TXDATA = 32'h8000_0008;
    localparam logic [31:0] A_STATUS = 32'h8000_000C;
    localparam logic [31:0] A_CMP    = 32'h8000_0010;

    initial begin
        model_reset();
        cyc();
        cyc();
        reset = 1'b0;

        @(negedge clk);
        check("reset_tx_valid", 32'(tx_valid), 32'h0);
        check("reset_gpio", 32'(gpio_out), 32'h0);
        cyc();

        wr(32'h0000_0010, 32'hDEAD_BEEF);
        rd(32'h0000_0010, 32'hDEAD_BEEF, "ram_load");
        rd(32'h4000_0000, 32'h0, "unmapped_load");

        wr(A_GPIO, 32'h0000_01A5);
        @(negedge clk);
        check("gpio_out", 32'(gpio_out), 32'h0000_00A5);
        rd(A_GPIO, 32'h0000_00A5, "gpio_read");

        wr(A_TIMER, 32'hFFFF_FFFE);
        cyc();
        cyc();
        rd(A_TIMER, 32'h0, "timer_wrap");
        wr(A_TIMER, 32'h1234_5678);
        rd(A_TIMER, 32'h1234_5678, "timer_load");

        tx_ready = 1'b0;
        for (int i = 1; i <= 9; i++) wr(A_TXDATA, 32'(i));
        rd(A_STATUS, 32'h0000_0806, "status_full_ovf");
        tx_ready = 1'b1;
        for (int i = 1; i <= 8; i++) drain_expect(8'(i), "drain_order");
        tx_ready = 1'b0;
        rd(A_STATUS, 32'h0000_0005, "status_empty_ovf");
        wr(A_STATUS, 32'h4);
        rd(A_STATUS, 32'h0000_0001, "ovf_clear");

        for (int i = 0; i < 8; i++) wr(A_TXDATA, 32'(8'hA0 + 8'(i)));
        rd(A_STATUS, 32'h0000_0802, "status_full");
        tx_ready = 1'b1;
        wr(A_TXDATA, 32'h55);
        tx_ready = 1'b0;
        rd(A_STATUS, 32'h0000_0802, "full_push_pop");
        tx_ready = 1'b1;
        for (int i = 1; i < 8; i++) drain_expect(8'hA0 + 8'(i), "drain_after_pp");
        drain_expect(8'h55, "drain_55_last");
        tx_ready = 1'b0;
        rd(A_STATUS, 32'h0000_0001, "status_drained");

`ifdef DMEM_TIMER_CMP_EN
        begin
            bit found;
            found = 1'b0;
            wr(A_CMP, 32'd20);
            rd(A_CMP, 32'd20, "cmp_read");
            wr(A_TIMER, 32'd0);
            mem_addr = A_TIMER;
            for (int n = 0; n < 40 && !found; n++) begin
                @(negedge clk);
                if (mem_rdata == 32'd20) begin
                    found = 1'b1;
                    check("irq_before_hit", 32'(irq), 32'h0);
                    cyc();
                    @(negedge clk);
                    check("irq_rise", 32'(irq), 32'h1);
                end
                cyc();
            end
            if (!found) check("irq_timer_timeout", 32'h0, 32'h1);
            wr(A_STATUS, 32'h8);
            @(negedge clk);
            check("irq_clear", 32'(irq), 32'h0);
            cyc();
            wr(A_CMP, 32'd4);
            wr(A_TIMER, 32'd0);
        end
`endif

        tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) wr(A_TXDATA, 32'(8'h30 + 8'(i)));
        @(negedge clk);
        check("pre_reset_valid", 32'(tx_valid), 32'h1);
`ifdef DMEM_TIMER_CMP_EN
        check("pre_reset_irq", 32'(irq), 32'h1);
`endif
        cyc();
        tx_ready = 1'b1;
        @(posedge clk);
        #3;
        reset = 1'b1;
        model_reset();
        #1;
        check("reset_mid_valid", 32'(tx_valid), 32'h0);
        check("reset_mid_irq", 32'(irq), 32'h0);
        check("reset_mid_data", 32'(tx_data), 32'h0);
        cyc();
        reset = 1'b0;
        tx_ready = 1'b0;
        rd(32'h0000_0010, 32'hDEAD_BEEF, "ram_survives_reset");

        for (int n = 0; n < 2000; n++) begin
            int          kind;
            logic [31:0] a;
            kind      = $urandom_range(0, 9);
            tx_ready  = ($urandom_range(0, 9) < 3);
            mem_we    = 1'b0;
            mem_wdata = $urandom;
            a = {4'h0, 18'($urandom), 4'h0, 4'($urandom_range(0, 15)), 2'($urandom)};
            case (kind)
                0, 1: mem_we = 1'b1;
                2, 3: ;
                4, 6: begin
                    a = {4'h8, 20'($urandom), 8'h00};
                    case ($urandom_range(0, 6))
                        0: a[7:0] = 8'h00;
                        1: a[7:0] = 8'h04;
                        2: a[7:0] = 8'h08;
                        3: a[7:0] = 8'h0C;
                        4: a[7:0] = 8'h10;
                        5: a[7:0] = 8'h14;
                        default: a[7:0] = 8'h40;
                    endcase
                    a[1:0] = 2'($urandom);
                    mem_we = (kind == 4);
                    if (a[7:2] == 6'h01 && $urandom_range(0, 1) == 1)
                        mem_wdata = m_cmp - 32'($urandom_range(0, 3));
                end
                5: begin
                    a = A_TXDATA;
                    mem_we = 1'b1;
                end
                7: begin
                    a = $urandom;
                    if (a[31:28] == 4'h0 || a[31:28] == 4'h8) a[31:28] = 4'h3;
                    mem_we = $urandom_range(0, 1);
                end
                default: a = A_STATUS;
            endcase
            mem_addr = a;
            cyc();
        end
        mem_we = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
